// File: rtl/rf_wb_pkg.sv
// Shared types and widths for the register-file write path.
package rf_wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/mc_result_buf.sv
// Circular buffer for multi-cycle results with kill-by-rd and two lookup ports.
// Killed entries stay in place as holes. A hole at the head is retired one per
// cycle. Holes at the young end are reclaimed immediately, so a hole only
// occupies a slot while a valid entry sits behind it.
module mc_result_buf
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [REG_AW-1:0]            push_rd,
  input  logic [XLEN-1:0]              push_data,
  input  logic                         pop,
  input  logic                         kill,
  input  logic [REG_AW-1:0]            kill_rd,
  input  logic [REG_AW-1:0]            look1,
  input  logic [REG_AW-1:0]            look2,
  output wb_entry_t                    head,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   vld_cnt,
  output logic [DEPTH-1:0]             match1,
  output logic [DEPTH-1:0]             match2
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t         mem [DEPTH];
  logic [PW-1:0]     hd;
  logic [CW-1:0]     occ;       // physical slots in use, holes included
  logic              skip;      // head leaves this cycle (popped or dead)
  logic [CW-1:0]     occ_trim;  // slots kept from the new head to the last survivor
  logic [PW-1:0]     hd_nxt;
  logic [PW-1:0]     wr_ptr;

  assign head = mem[hd];
  // A new entry needs a free physical slot; a dead head being retired frees one.
  assign full = (occ == CW'(DEPTH)) && mem[hd].valid;

  // Retire the head, apply the kill, and find the last surviving entry.
  always_comb begin
    skip     = (occ != '0) && (!mem[hd].valid || pop);
    occ_trim = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < occ) && !(skip && (i == 0)) &&
          mem[hd + PW'(i)].valid &&
          !(kill && (mem[hd + PW'(i)].rd == kill_rd))) begin
        occ_trim = CW'(i + 1) - CW'(skip);
      end
    end
    hd_nxt = hd + PW'(skip);
    wr_ptr = hd_nxt + PW'(occ_trim);
  end

  // Valid-entry count and lookup match vectors.
  always_comb begin
    vld_cnt = '0;
    match1  = '0;
    match2  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld_cnt   = vld_cnt + CW'(mem[i].valid);
      match1[i] = mem[i].valid && (mem[i].rd == look1);
      match2[i] = mem[i].valid && (mem[i].rd == look2);
    end
  end

  // Pointer and storage update; a push into a just-retired slot takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hd  <= '0;
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      hd  <= hd_nxt;
      occ <= occ_trim + CW'(push);
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && (mem[i].rd == kill_rd)) mem[i].valid <= 1'b0;
      end
      if (skip) mem[hd].valid <= 1'b0;
      if (push) mem[wr_ptr] <= '{valid: 1'b1, rd: push_rd, data: push_data};
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Single RF write port shared by pipeline writeback and buffered multi-cycle results.
// Pipeline writes always win; buffered results drain in free slots.
module rf_write_arbiter
  import rf_wb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [REG_AW-1:0] mc_rd,
  input  logic [XLEN-1:0]   mc_data,
  input  logic [REG_AW-1:0] chk_rs1,
  input  logic [REG_AW-1:0] chk_rs2,
  output logic              pend1,
  output logic              pend2,
  output logic              stall_req,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata
);
  localparam int              SW        = $clog2(STARVE_MAX + 1);
  localparam int              CW        = $clog2(DEPTH + 1);
  localparam logic [SW-1:0]   STARVE_TC = SW'(STARVE_MAX - 1);

  wb_entry_t         head;
  logic              buf_full;
  logic [CW-1:0]     vld_cnt;
  logic [DEPTH-1:0]  match1, match2;
  logic              wb_use, pop_en, push_en, buf_empty, blocked;
  logic [SW-1:0]     starve_cnt;

  assign wb_use    = wb_valid && (wb_rd != '0);
  assign pop_en    = !wb_use && head.valid;
  assign mc_ready  = !buf_full;
  // rd 0 results are accepted and dropped; a same-rd pipeline write makes the older result dead.
  assign push_en   = mc_valid && mc_ready && (mc_rd != '0) && !(wb_use && (mc_rd == wb_rd));
  assign buf_empty = (vld_cnt == '0);
  assign blocked   = wb_use && !buf_empty;

  assign pend1 = (chk_rs1 != '0) && ((|match1) || (rf_we && (rf_waddr == chk_rs1)));
  assign pend2 = (chk_rs2 != '0) && ((|match2) || (rf_we && (rf_waddr == chk_rs2)));

  mc_result_buf #(.DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push_en),
    .push_rd   (mc_rd),
    .push_data (mc_data),
    .pop       (pop_en),
    .kill      (wb_use),
    .kill_rd   (wb_rd),
    .look1     (chk_rs1),
    .look2     (chk_rs2),
    .head      (head),
    .full      (buf_full),
    .vld_cnt   (vld_cnt),
    .match1    (match1),
    .match2    (match2)
  );

  // Registered RF write port: pipeline result first, else buffer head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (wb_use) begin
      rf_we    <= 1'b1;
      rf_waddr <= wb_rd;
      rf_wdata <= wb_data;
    end else if (pop_en) begin
      rf_we    <= 1'b1;
      rf_waddr <= head.rd;
      rf_wdata <= head.data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Starvation tracking: count blocked cycles, request a pipeline bubble at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      if (pop_en || buf_empty) begin
        starve_cnt <= '0;
        stall_req  <= 1'b0;
      end else if (blocked) begin
        if (starve_cnt == STARVE_TC) stall_req  <= 1'b1;
        else                         starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed bench for rf_write_arbiter against a queue-level model.
module tb_rf_write_arbiter;
  import rf_wb_pkg::*;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wb_valid = 1'b0;
  logic [REG_AW-1:0] wb_rd = '0;
  logic [XLEN-1:0]   wb_data = '0;
  logic              mc_valid = 1'b0;
  logic              mc_ready;
  logic [REG_AW-1:0] mc_rd = '0;
  logic [XLEN-1:0]   mc_data = '0;
  logic [REG_AW-1:0] chk_rs1 = '0;
  logic [REG_AW-1:0] chk_rs2 = '0;
  logic              pend1, pend2, stall_req, rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .pend1(pend1), .pend2(pend2),
    .stall_req(stall_req), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  // Model: buffered results in age order; killed ones linger as dead records.
  typedef struct {
    bit              v;
    int              rd;
    logic [XLEN-1:0] data;
  } rec_t;

  rec_t            q[$];
  bit              m_we;
  int              m_waddr;
  logic [XLEN-1:0] m_wdata;
  int              m_cnt;
  bit              m_stall;
  int              n_checks = 0;
  int              n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int vcnt();
    int n = 0;
    foreach (q[i]) if (q[i].v) n++;
    return n;
  endfunction

  function automatic bit mpend(input logic [REG_AW-1:0] rs);
    if (rs == 0) return 1'b0;
    if (m_we && (m_waddr == int'(rs))) return 1'b1;
    foreach (q[i]) if (q[i].v && (q[i].rd == int'(rs))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_we = 0; m_waddr = 0; m_wdata = '0; m_cnt = 0; m_stall = 0;
  endtask

  task automatic compare();
    chk("rf_we", rf_we, m_we);
    if (m_we) begin
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
    end
    chk("mc_ready", mc_ready, vcnt() < DEPTH);
    chk("stall_req", stall_req, m_stall);
    chk("pend1", pend1, mpend(chk_rs1));
    chk("pend2", pend2, mpend(chk_rs2));
    if (wb_valid && stall_req) begin
      n_fail++;
      $display("FAIL protocol: wb_valid=1 while stall_req=1 (t=%0t)", $time);
    end
  endtask

  // Advance the model across one posedge using the inputs now driven.
  task automatic step();
    bit wuse, ready, had_valid, front_dead, popped;
    wuse       = wb_valid && (wb_rd != 0);
    ready      = vcnt() < DEPTH;
    had_valid  = vcnt() > 0;
    front_dead = (q.size() > 0) && !q[0].v;
    popped     = 0;
    if (wuse) begin
      m_we = 1; m_waddr = wb_rd; m_wdata = wb_data;
      foreach (q[i]) if (q[i].rd == int'(wb_rd)) q[i].v = 0;
    end else if ((q.size() > 0) && q[0].v) begin
      m_we = 1; m_waddr = q[0].rd; m_wdata = q[0].data;
      void'(q.pop_front());
      popped = 1;
    end else begin
      m_we = 0;
    end
    if (front_dead) void'(q.pop_front());
    while ((q.size() > 0) && !q[q.size()-1].v) void'(q.pop_back());
    if (mc_valid && ready && (mc_rd != 0) && !(wuse && (mc_rd == wb_rd)))
      q.push_back('{v: 1'b1, rd: int'(mc_rd), data: mc_data});
    if (popped || !had_valid) begin
      m_cnt = 0; m_stall = 0;
    end else if (wuse) begin
      if (m_cnt == STARVE_MAX - 1) m_stall = 1;
      else                         m_cnt++;
    end
  endtask

  task automatic cycle(input bit r, input bit wv, input int wrd, input logic [XLEN-1:0] wd,
                       input bit mv, input int mrd, input logic [XLEN-1:0] md,
                       input int r1, input int r2, output bit acc);
    @(negedge clk);
    rst = r; wb_valid = wv; wb_rd = REG_AW'(wrd); wb_data = wd;
    mc_valid = mv; mc_rd = REG_AW'(mrd); mc_data = md;
    chk_rs1 = REG_AW'(r1); chk_rs2 = REG_AW'(r2);
    #1;
    if (r) model_reset();
    compare();
    acc = mv && !r && (vcnt() < DEPTH);
    if (!r) step();
  endtask

  task automatic idle(input int r1, input int r2);
    bit d;
    cycle(0, 0, 0, '0, 0, 0, '0, r1, r2, d);
  endtask

  initial begin
    bit d, acc, mc_pend;
    int mrd, wpct;
    logic [XLEN-1:0] mdat;
    model_reset();
    #1 rst = 1'b1;
    cycle(1, 0, 0, '0, 0, 0, '0, 5, 0, d);
    cycle(1, 0, 0, '0, 0, 0, '0, 5, 0, d);
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_ready", mc_ready, 1);

    // Pipeline write, latency one.
    cycle(0, 1, 5, 32'hA5, 0, 0, '0, 0, 0, d);
    idle(0, 0);
    chk("wb_we", rf_we, 1); chk("wb_waddr", rf_waddr, 5); chk("wb_wdata", rf_wdata, 32'hA5);
    idle(0, 0);
    chk("wb_we_drop", rf_we, 0);

    // Multi-cycle result through an idle slot, pending while in flight.
    cycle(0, 0, 0, '0, 1, 7, 32'h11, 7, 0, d);
    idle(7, 0);
    chk("mc_pend_buf", pend1, 1); chk("mc_we_early", rf_we, 0);
    idle(7, 0);
    chk("mc_we", rf_we, 1); chk("mc_waddr", rf_waddr, 7); chk("mc_wdata", rf_wdata, 32'h11);
    chk("mc_pend_out", pend1, 1);
    idle(7, 0);
    chk("mc_pend_clear", pend1, 0);

    // Fill under continuous pipeline writes, starvation, ordered drain.
    cycle(0, 1, 10, 32'h10, 1, 3, 32'h300, 3, 4, d);
    cycle(0, 1, 11, 32'h11, 1, 4, 32'h400, 3, 4, d);
    cycle(0, 1, 12, 32'h12, 0, 0, '0, 3, 4, d);
    chk("fill_ready", mc_ready, 0); chk("fill_pend3", pend1, 1); chk("fill_pend4", pend2, 1);
    cycle(0, 1, 13, 32'h13, 0, 0, '0, 3, 4, d);
    cycle(0, 1, 14, 32'h14, 0, 0, '0, 3, 4, d);
    chk("starve_3", stall_req, 0);
    idle(3, 4);
    chk("starve_4", stall_req, 1);
    idle(3, 4);
    chk("drain1_addr", rf_waddr, 3); chk("drain1_data", rf_wdata, 32'h300);
    chk("drain1_we", rf_we, 1); chk("stall_fall", stall_req, 0);
    idle(3, 4);
    chk("drain2_addr", rf_waddr, 4); chk("drain2_data", rf_wdata, 32'h400);
    idle(0, 0);
    idle(0, 0);

    // WAW kill of a buffered result.
    cycle(0, 1, 20, 32'h20, 1, 9, 32'h22, 9, 0, d);
    cycle(0, 1, 9, 32'h33, 0, 0, '0, 9, 0, d);
    chk("waw_pend_buf", pend1, 1);
    idle(9, 0);
    chk("waw_we", rf_we, 1); chk("waw_waddr", rf_waddr, 9); chk("waw_wdata", rf_wdata, 32'h33);
    idle(9, 0);
    chk("waw_no_old", rf_we, 0); chk("waw_pend_clear", pend1, 0);
    idle(9, 0);
    chk("waw_no_old2", rf_we, 0);

    // rd 0 result accepted and discarded.
    cycle(0, 0, 0, '0, 1, 0, 32'h55, 0, 0, d);
    idle(0, 0);
    chk("rd0_ready", mc_ready, 1); chk("rd0_pend", pend1, 0);
    idle(0, 0);
    chk("rd0_we", rf_we, 0);

    // Reset with two buffered results.
    cycle(0, 1, 21, 32'h21, 1, 12, 32'hC, 12, 13, d);
    cycle(0, 1, 22, 32'h22, 1, 13, 32'hD, 12, 13, d);
    cycle(1, 0, 0, '0, 0, 0, '0, 12, 13, d);
    chk("rstm_we", rf_we, 0); chk("rstm_ready", mc_ready, 1); chk("rstm_pend", pend1, 0);
    cycle(1, 0, 0, '0, 0, 0, '0, 12, 13, d);
    for (int k = 0; k < 3; k++) begin
      idle(12, 13);
      chk("rstm_no_write", rf_we, 0);
    end

    // Randomized traffic; the multi-cycle source holds its offer until accepted.
    mc_pend = 0; mrd = 0; mdat = '0;
    for (int n = 0; n < 4000; n++) begin
      bit r, wv;
      wpct = (n < 2000) ? 85 : 35;
      r = ($urandom_range(0, 499) == 0);
      wv = !m_stall && ($urandom_range(0, 99) < wpct);
      if (!mc_pend && ($urandom_range(0, 99) < 45)) begin
        mc_pend = 1; mrd = $urandom_range(0, 7); mdat = $urandom;
      end
      cycle(r, wv, $urandom_range(0, 7), $urandom, mc_pend, mrd, mdat,
            $urandom_range(0, 7), $urandom_range(0, 7), acc);
      if (acc || r) mc_pend = 0;
    end
    idle(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
